// File: rtl/mem_burst_master.sv
// Burst initiator for the byte-addressed 32-bit MEMORY port: sequences write/read bursts word by word.
// Optional macro MEM_BURST_MASTER_ALIGN_CHECK_EN rejects unaligned start addresses with ERR+DONE.
module mem_burst_master #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_RW,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic              WD_VALID,
  output logic              WD_READY,
  input  logic [31:0]       WD_DATA,
  output logic              RD_VALID,
  output logic [31:0]       RD_DATA,
  output logic              DONE,
  output logic              ERR,
  output logic              BUSY,
  output logic              MEM_VALID,
  output logic              MEM_RW,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DIN,
  input  logic [31:0]       MEM_DOUT
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RDRAIN, FINISH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        pend_q, pend_d;
  logic              err_flag_q, err_flag_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              rd_valid_q, rd_valid_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic cmd_fire;
  logic wd_fire;
  logic misaligned;

`ifdef MEM_BURST_MASTER_ALIGN_CHECK_EN
  assign misaligned = (CMD_ADDR[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign CMD_READY = (state_q == IDLE);
  assign BUSY      = (state_q != IDLE);
  assign WD_READY  = (state_q == WRITE) && (rem_q != '0);
  assign cmd_fire  = CMD_VALID && CMD_READY;
  assign wd_fire   = WD_VALID && WD_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (CMD_LEN == '0 || misaligned) state_d = FINISH;
          else if (CMD_RW)                 state_d = WRITE;
          else                             state_d = READ;
        end
      end
      WRITE:  if (wd_fire && rem_q == LEN_W'(1)) state_d = FINISH;
      READ:   if (rem_q == LEN_W'(1))            state_d = RDRAIN;
      // Leave once no issue is younger than the word returning this edge.
      RDRAIN: if (!pend_q[0])                    state_d = IDLE;
      FINISH:                                    state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    err_flag_d  = err_flag_q;
    mem_valid_d = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    pend_d      = {pend_q[0], 1'b0};
    rd_valid_d  = pend_q[1];
    rd_data_d   = pend_q[1] ? MEM_DOUT : rd_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d     = CMD_ADDR;
          rem_d      = CMD_LEN;
          err_flag_d = misaligned;
        end
      end
      WRITE: begin
        if (wd_fire) begin
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_din_d   = WD_DATA;
          addr_d      = addr_q + ADDR_W'(4);
          rem_d       = rem_q - LEN_W'(1);
        end
      end
      READ: begin
        mem_valid_d = 1'b1;
        mem_rw_d    = 1'b0;
        mem_addr_d  = addr_q;
        pend_d[0]   = 1'b1;
        addr_d      = addr_q + ADDR_W'(4);
        rem_d       = rem_q - LEN_W'(1);
      end
      RDRAIN: done_d = !pend_q[0];
      FINISH: begin
        done_d = 1'b1;
        err_d  = err_flag_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q      <= '0;
      rem_q       <= '0;
      err_flag_q  <= 1'b0;
      pend_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      err_flag_q  <= err_flag_d;
      pend_q      <= pend_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign MEM_VALID = mem_valid_q;
  assign MEM_RW    = mem_rw_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_DIN   = mem_din_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_data_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a byte-addressed MEMORY model (registered read data).
// Expectations for the unaligned case follow MEM_BURST_MASTER_ALIGN_CHECK_EN.
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, err, busy;
  logic        mem_valid, mem_rw;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = '0;

  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;
  int acc_cyc      = 0;

  logic [7:0]  mem [256];

  int          mv_n = 0, rd_n = 0, done_n = 0, err_n = 0, wdr_n = 0;
  int          mv_cyc [32];
  logic [7:0]  mv_addr [32];
  logic        mv_rw [32];
  int          rd_cyc [32];
  logic [31:0] rd_dat [32];
  int          done_cyc [32];

  mem_burst_master #(.ADDR_W(8), .LEN_W(4)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_RW(cmd_rw),
    .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len),
    .WD_VALID(wd_valid), .WD_READY(wd_ready), .WD_DATA(wd_data),
    .RD_VALID(rd_valid), .RD_DATA(rd_data),
    .DONE(done), .ERR(err), .BUSY(busy),
    .MEM_VALID(mem_valid), .MEM_RW(mem_rw), .MEM_ADDR(mem_addr),
    .MEM_DIN(mem_din), .MEM_DOUT(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
  endfunction

  // MEMORY model: commits writes and registers read data on the edge after the request.
  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_rw) begin
        for (int k = 0; k < 4; k++) mem[8'(mem_addr + 8'(k))] = mem_din[31-8*k -: 8];
      end else begin
        mem_dout <= rd_word(mem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_valid && mv_n < 32) begin
        mv_cyc[mv_n] = cyc; mv_addr[mv_n] = mem_addr; mv_rw[mv_n] = mem_rw; mv_n++;
      end
      if (rd_valid && rd_n < 32) begin
        rd_cyc[rd_n] = cyc; rd_dat[rd_n] = rd_data; rd_n++;
      end
      if (done && done_n < 32) begin
        done_cyc[done_n] = cyc; done_n++;
      end
      if (err) err_n++;
      if (wd_ready) wdr_n++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    #1;
    mv_n = 0; rd_n = 0; done_n = 0; err_n = 0; wdr_n = 0;
    for (int i = 0; i < 32; i++) begin
      mv_cyc[i] = -1; mv_addr[i] = '0; mv_rw[i] = 1'bx; rd_cyc[i] = -1; rd_dat[i] = '0; done_cyc[i] = -1;
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [7:0] addr, input logic [3:0] len);
    @(negedge clk);
    checkOutput("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_len = len;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data);
    int n;
    n = 0;
    @(negedge clk);
    wd_valid = 1'b1; wd_data = data;
    while (!wd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wd_ready_timeout", {31'd0, wd_ready}, 32'd1);
    @(posedge clk);
    #1;
    wd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0;
    clear_logs();
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_flags", {25'd0, mem_valid, mem_rw, rd_valid, done, err, busy, wd_ready}, 32'd0);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_din", mem_din, 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_no_access", mv_n, 0);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    // Write burst len=2 at 0x00
    clear_logs();
    applyStimulus(1'b1, 8'h00, 4'd2);
    send_beat(32'hACBD4432);
    send_beat(32'hDFD6BB42);
    wait_idle("t2");
    checkOutput("t2_access_count", mv_n, 2);
    checkOutput("t2_addr0", {24'd0, mv_addr[0]}, 32'h00);
    checkOutput("t2_addr1", {24'd0, mv_addr[1]}, 32'h04);
    checkOutput("t2_rw", {30'd0, mv_rw[0], mv_rw[1]}, 32'd3);
    checkOutput("t2_issue_cycles", mv_cyc[1] - mv_cyc[0], 1);
    checkOutput("t2_word0", rd_word(8'h00), 32'hACBD4432);
    checkOutput("t2_word1", rd_word(8'h04), 32'hDFD6BB42);
    checkOutput("t2_byte7", {24'd0, mem[7]}, 32'h42);
    checkOutput("t2_done_count", done_n, 1);
    checkOutput("t2_done_cycle", done_cyc[0], acc_cyc + 3);

    // Read burst len=2 at 0x00
    clear_logs();
    applyStimulus(1'b0, 8'h00, 4'd2);
    wait_idle("t3");
    checkOutput("t3_access_count", mv_n, 2);
    checkOutput("t3_issue0_cycle", mv_cyc[0], acc_cyc + 1);
    checkOutput("t3_issue1_cycle", mv_cyc[1], acc_cyc + 2);
    checkOutput("t3_rw", {30'd0, mv_rw[0], mv_rw[1]}, 32'd0);
    checkOutput("t3_rd_count", rd_n, 2);
    checkOutput("t3_rd0", rd_dat[0], 32'hACBD4432);
    checkOutput("t3_rd1", rd_dat[1], 32'hDFD6BB42);
    checkOutput("t3_rd0_cycle", rd_cyc[0], acc_cyc + 3);
    checkOutput("t3_rd1_cycle", rd_cyc[1], acc_cyc + 4);
    checkOutput("t3_done_count", done_n, 1);
    checkOutput("t3_done_cycle", done_cyc[0], acc_cyc + 4);

    // Zero-length read
    clear_logs();
    applyStimulus(1'b0, 8'h40, 4'd0);
    wait_idle("t3z");
    checkOutput("t3z_access_count", mv_n, 0);
    checkOutput("t3z_rd_count", rd_n, 0);
    checkOutput("t3z_done_count", done_n, 1);
    checkOutput("t3z_done_cycle", done_cyc[0], acc_cyc + 1);

    // Write len=3 with a 3-cycle stall after the first beat
    clear_logs();
    applyStimulus(1'b1, 8'h10, 4'd3);
    send_beat(32'h11111111);
    repeat (3) @(negedge clk);
    send_beat(32'h22222222);
    send_beat(32'h33333333);
    wait_idle("t4");
    checkOutput("t4_access_count", mv_n, 3);
    checkOutput("t4_issue0_cycle", mv_cyc[0], acc_cyc + 1);
    checkOutput("t4_issue1_cycle", mv_cyc[1], acc_cyc + 5);
    checkOutput("t4_issue2_cycle", mv_cyc[2], acc_cyc + 6);
    checkOutput("t4_addr2", {24'd0, mv_addr[2]}, 32'h18);
    checkOutput("t4_word1", rd_word(8'h14), 32'h22222222);
    checkOutput("t4_word2", rd_word(8'h18), 32'h33333333);
    checkOutput("t4_done_cycle", done_cyc[0], acc_cyc + 7);

    // Address wrap 0xFC -> 0x00
    clear_logs();
    applyStimulus(1'b1, 8'hFC, 4'd2);
    send_beat(32'hA5A5A5A5);
    send_beat(32'h5A5A5A5A);
    wait_idle("t4w");
    checkOutput("t4w_addr0", {24'd0, mv_addr[0]}, 32'hFC);
    checkOutput("t4w_addr1", {24'd0, mv_addr[1]}, 32'h00);
    checkOutput("t4w_wordFC", rd_word(8'hFC), 32'hA5A5A5A5);
    checkOutput("t4w_word00", rd_word(8'h00), 32'h5A5A5A5A);

    // Reset pulse in the middle of a read burst
    clear_logs();
    applyStimulus(1'b0, 8'h10, 4'd4);
    begin
      int n;
      n = 0;
      while (!mem_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("t5_first_issue", {31'd0, mem_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1 checkOutput("t5_in_reset", {29'd0, cmd_ready, mem_valid, busy}, 32'b100);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("t5_no_rd_valid", rd_n, 0);
    checkOutput("t5_no_done", done_n, 0);
    checkOutput("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Unaligned write start
    clear_logs();
    applyStimulus(1'b1, 8'h02, 4'd1);
`ifdef MEM_BURST_MASTER_ALIGN_CHECK_EN
    wait_idle("t6");
    checkOutput("t6_access_count", mv_n, 0);
    checkOutput("t6_wd_ready_cycles", wdr_n, 0);
    checkOutput("t6_done_count", done_n, 1);
    checkOutput("t6_err_count", err_n, 1);
    checkOutput("t6_done_cycle", done_cyc[0], acc_cyc + 1);
`else
    send_beat(32'hCAFEF00D);
    wait_idle("t6");
    checkOutput("t6_access_count", mv_n, 1);
    checkOutput("t6_addr0", {24'd0, mv_addr[0]}, 32'h02);
    checkOutput("t6_word", rd_word(8'h02), 32'hCAFEF00D);
    checkOutput("t6_done_count", done_n, 1);
    checkOutput("t6_err_count", err_n, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
